// File: rtl/ice_uart_frame_rx.sv
// ice_uart_frame_rx
//
// Purpose:
//   Assembles ICE command frames from the byte stream delivered by the
//   host-side uart receiver. A frame on the wire is
//     [type][event_id][len][len payload bytes]
//   The three header bytes are held in registers. The payload is buffered in
//   an internal first-word-fall-through FIFO. The frame is presented to the
//   command dispatcher only after its last byte has arrived. If the gap
//   between two bytes of one frame reaches TIMEOUT, the partial frame is
//   discarded.
//
// Parameters:
//   DEPTH    payload FIFO depth in bytes (power of 2, >= 256)
//   TIMEOUT  maximum clk cycles allowed between two bytes of one frame
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   rx_latch      one-cycle strobe: rx_data carries a received byte
//   rx_data       received byte
//   frm_valid     a complete frame is held; frm_type/frm_id/frm_len are stable
//   frm_type      frame type byte
//   frm_id        event id byte
//   frm_len       payload length (0..255)
//   pay_valid     a payload byte is available on pay_data
//   pay_data      payload byte at the FIFO head (0 when pay_valid is low)
//   pay_ready     consumer accepts pay_data
//   frm_ack       one-cycle strobe: consumer releases the held frame
//   err_overflow  one-cycle pulse: a byte arrived while a frame was held
//   err_timeout   one-cycle pulse: a partial frame was discarded
//   state_dbg     current parser state (debug observation only)
//
// Handshake:
//   A payload byte transfers on a rising clk edge where pay_valid and
//   pay_ready are both high. pay_valid only rises while a complete frame is
//   held, and it never drops without a transfer unless frm_ack releases the
//   frame. The producer side has no back-pressure: rx_latch is a strobe.

module ice_uart_frame_rx #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_latch,
  input  logic [7:0] rx_data,
  output logic       frm_valid,
  output logic [7:0] frm_type,
  output logic [7:0] frm_id,
  output logic [7:0] frm_len,
  output logic       pay_valid,
  output logic [7:0] pay_data,
  input  logic       pay_ready,
  input  logic       frm_ack,
  output logic       err_overflow,
  output logic       err_timeout,
  output logic [2:0] state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GOT_TYPE = 3'd1,
    S_GOT_ID   = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t state, state_next;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    cnt;
  logic [TW-1:0] idle_cnt;

  logic load_type, load_id, load_len, push, pop, flush;
  logic in_frame, timeout_hit, ovf;
  logic fifo_empty;

  // Pointers carry one extra bit so full and empty are distinguishable.
  // A frame never holds more than 255 bytes, so full is unreachable.
  assign fifo_empty = (wr_ptr == rd_ptr);

  // The inter-byte timer only runs while a frame is partially received.
  assign in_frame = (state == S_GOT_TYPE) || (state == S_GOT_ID) ||
                    (state == S_PAYLOAD);

  // A byte arriving on the expiry cycle keeps the frame alive.
  assign timeout_hit = in_frame && !rx_latch && (idle_cnt == TO_LAST);

  always_comb begin
    state_next = state;
    load_type  = 1'b0;
    load_id    = 1'b0;
    load_len   = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    ovf        = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_latch) begin
          load_type  = 1'b1;
          state_next = S_GOT_TYPE;
        end
      end
      S_GOT_TYPE: begin
        if (rx_latch) begin
          load_id    = 1'b1;
          state_next = S_GOT_ID;
        end else if (timeout_hit) begin
          flush      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_GOT_ID: begin
        if (rx_latch) begin
          load_len   = 1'b1;
          state_next = (rx_data == 8'd0) ? S_HOLD : S_PAYLOAD;
        end else if (timeout_hit) begin
          flush      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (rx_latch) begin
          push = 1'b1;
          // frm_len is at least 1 here, so len-1 does not underflow.
          if (cnt == frm_len - 8'd1) begin
            state_next = S_HOLD;
          end
        end else if (timeout_hit) begin
          flush      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_HOLD: begin
        // While a frame is held, incoming bytes are dropped.
        // This includes the cycle on which the frame is released.
        ovf = rx_latch;
        if (frm_ack) begin
          flush      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // A release on the same cycle supersedes a pop; the flush empties the FIFO.
  assign pop = (state == S_HOLD) && !fifo_empty && pay_ready && !frm_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      frm_type     <= 8'd0;
      frm_id       <= 8'd0;
      frm_len      <= 8'd0;
      cnt          <= 8'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      idle_cnt     <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_next;
      err_overflow <= ovf;
      err_timeout  <= timeout_hit;

      if (load_type) begin
        frm_type <= rx_data;
      end
      if (load_id) begin
        frm_id <= rx_data;
      end
      if (load_len) begin
        frm_len <= rx_data;
        cnt     <= 8'd0;
      end else if (push) begin
        cnt <= cnt + 8'd1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      // Flushing discards whatever is left of the current frame.
      // No push can coincide with a flush.
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      if (rx_latch || !in_frame || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= rx_data;
    end
  end

  assign frm_valid = (state == S_HOLD);
  assign pay_valid = (state == S_HOLD) && !fifo_empty;
  // The data is gated so that pay_data reads 0 whenever nothing is offered,
  // including straight after reset when the storage is uninitialised.
  assign pay_data  = pay_valid ? mem[rd_ptr[AW-1:0]] : 8'd0;
  assign state_dbg = state;

endmodule
